// File: rtl/mongyro_axil_regs.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit control registers, with a
// one-cycle write strobe per register. One outstanding write and one outstanding read.
module mongyro_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  function automatic logic [IDX_W-1:0] reg_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    if (NUM_REGS > 1) return addr[2 +: IDX_W];
    else              return '0;
  endfunction

  logic             aw_held_q, aw_held_d;
  logic [IDX_W-1:0] aw_idx_q,  aw_idx_d;
  logic             w_held_q,  w_held_d;
  logic [DW-1:0]    wdata_q,   wdata_d;
  logic [SW-1:0]    wstrb_q,   wstrb_d;
  logic             bvalid_q,  bvalid_d;
  logic             rvalid_q,  rvalid_d;
  logic [DW-1:0]    rdata_q,   rdata_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic [DW-1:0]    regs_d [NUM_REGS];

  logic aw_hs, w_hs, ar_hs, commit;

  // Readies depend only on internal flops, never on the master's valids.
  assign S_AXI_AWREADY = ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = ~w_held_q  & ~bvalid_q;
  assign S_AXI_ARREADY = ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign wr_pulse      = pulse_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (commit) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb_q[b]) regs_d[aw_idx_q][8*b +: 8] = wdata_q[8*b +: 8];
      end
      pulse_d[aw_idx_q] = 1'b1;
      bvalid_d  = 1'b1;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = reg_idx(S_AXI_AWADDR);
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
  end

  // Read samples regs_q, so a read racing a commit returns the pre-write value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[reg_idx(S_AXI_ARADDR)];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign reg_out[DW*gi +: DW] = regs_q[gi];
  end

  // PROT and the address bits outside the register index carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: doc/mongyro_axil_regs.md
Name: mongyro_axil_regs

Overview:
AXI4-Lite slave (responder) register bank for the mongyrocopse IP.
- Terminates the AXI4-Lite master port driven by the block-design VIP master / PS interconnect.
- Exposes NUM_REGS 32-bit read/write control registers to user logic.
- Emits a per-register one-cycle write pulse.
- One outstanding write and one outstanding read; read and write channels operate concurrently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width
NUM_REGS, 4, number of registers; power of two, 2^(C_S_AXI_ADDR_WIDTH-2) or fewer

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00 (OKAY)
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  32*NUM_REGS  register contents; reg i at [32*i+31:32*i]
wr_pulse  out  NUM_REGS  one-cycle strobe per written register

Behaviour:
Clocking and reset:
- One clock, S_AXI_ACLK. Reset is synchronous and active-high, S_AXI_ARESET.
- Reset values: all registers 0; BVALID, RVALID, wr_pulse 0; RDATA 0; BRESP/RRESP 2'b00; AW/W holding flags clear.

Address decode:
- Register index = ADDR[2 +: log2(NUM_REGS)].
- ADDR[1:0] and bits above the index are ignored; higher addresses alias.
- No SLVERR/DECERR. PROT is ignored.

Write channel:
- AW and W are accepted independently, in either order or in the same cycle.
- AWREADY = ~aw_held & ~BVALID. WREADY = ~w_held & ~BVALID. Both are combinational from internal flops only; no input-to-output path.
- A handshake latches the address or the data+strobe and sets the matching held flag.
- Commit cycle: aw_held & w_held & ~BVALID. On the next edge:
  - bytes of reg[idx] with WSTRB[b]=1 are updated;
  - BVALID=1;
  - wr_pulse[idx]=1 for exactly one cycle;
  - both held flags clear.
- WSTRB=0 still produces a response and a pulse; no bytes change.
- BVALID holds until BVALID & BREADY. While BVALID=1, AWREADY=WREADY=0, so a second write stalls.
- Best-case latency: AW+W handshake in cycle N, commit N+1, BVALID visible N+2.

Read channel:
- ARREADY = ~RVALID.
- On AR handshake, RDATA is loaded from reg[idx] and RVALID=1 at the next edge, so data is visible one cycle after the handshake.
- RDATA and RVALID hold stable until RVALID & RREADY.
- Read and write to the same register at the same edge: the read returns the pre-write value.

reg_out:
- Reflects the flop values directly.
- Updates in the same cycle BVALID rises.

Reset mid-transaction:
- Discards held AW/W and pending responses.
- The master must not expect a B or R response for a transaction in flight at reset.

Test Plan:
1. Sequential writes: 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, WSTRB=0xF. Read back in the same order -> RDATA 1, 2, 3, 4, all RRESP=OKAY; reg_out = {4,3,2,1}; wr_pulse 0001, 0010, 0100, 1000 once each.
2. Partial strobe: reg1=0x11223344, then write 0xAABBCCDD to 0x4 with WSTRB=0x5 -> read 0x11BB33DD.
3. W valid 3 cycles before AW -> WREADY handshake first, AWREADY accepts later; exactly one commit; BVALID exactly 2 cycles after the AW handshake.
4. Backpressure:
   - Hold BREADY=0 for 5 cycles after BVALID -> BVALID stays 1; AWREADY=WREADY=0; a second pending write is not accepted until the cycle after the B handshake.
   - Hold RREADY=0 -> RDATA stable, ARREADY=0.
5. Read of 0x8 in the same cycle as a commit of 0xDEADBEEF to 0x8 (old value 0x3) -> RDATA=0x3; a subsequent read returns 0xDEADBEEF.
6. Assert S_AXI_ARESET for 1 cycle while BVALID=1 and RVALID=1 -> next cycle BVALID=RVALID=0, all reg_out=0, AWREADY=WREADY=ARREADY=1.
